// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS core: sequencing-FSM state
// encodings and the opcodes that the ID stage decodes.
package cpu_pkg;

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] LB   = 6'b100000;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] SB   = 6'b101000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] BGTZ = 6'b000111;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] JAL  = 6'b000011;

  function automatic logic is_load(input logic [5:0] op);
    return (op == LW) || (op == LB);
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return is_load(op) || (op == SW) || (op == SB);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; used for the stall performance count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hold/kill controller: memory-port wait stalls, load-use bubbles
// and taken-branch flushes, in that priority order.
//
//   state | meaning
//   RUN   | normal flow; a memory request here starts the wait
//   WAIT  | memory port busy, cnt cycles of stall remaining
//   DONE  | access served this cycle, pipeline advances
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_write_reg,
  input  logic             mem_req,
  input  logic             branch_taken,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int CW = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] CNT_INIT = (MEM_WAIT >= 2) ? CW'(MEM_WAIT - 1) : '0;
  localparam bit MEM_EN   = (MEM_WAIT >= 1);
  localparam bit MEM_LONG = (MEM_WAIT >= 2);

  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          mstall, lu;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      RUN: begin
        if (mem_req && MEM_LONG) begin
          state_nx = WAIT;
          cnt_nx   = CNT_INIT;
        end else if (mem_req && MEM_EN) begin
          state_nx = DONE;
        end
      end
      WAIT: begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1))
          state_nx = DONE;
      end
      DONE:    state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign mstall = ((state == RUN) && mem_req && MEM_EN) || (state == WAIT);

  assign lu = ex_mem_read && (ex_write_reg != 5'd0) &&
              ((id_uses_rs && (id_rs == ex_write_reg)) ||
               (id_uses_rt && (id_rt == ex_write_reg)));

  // Strobes are qualified by rst_n so they drop with reset, not a clock later.
  assign stall_if  = rst_n && (mstall || lu);
  assign stall_id  = rst_n && (mstall || lu);
  assign stall_ex  = rst_n && mstall;
  assign bubble_ex = rst_n && !mstall && lu;
  assign flush_id  = rst_n && branch_taken && !mstall && !lu;
  assign state_o   = state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_if),
    .q     (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (MEM_WAIT 2/4/0) share stimulus.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_write_reg = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_mem_read = 1'b0;
  logic       mem_req = 1'b0, branch_taken = 1'b0;

  logic        a_if, a_id, a_ex, a_bub, a_fl;
  logic [1:0]  a_state;
  logic [15:0] a_cyc;
  logic        b_if, b_id, b_ex, b_bub, b_fl;
  logic [1:0]  b_state;
  logic [1:0]  b_cyc;
  logic        c_if, c_id, c_ex, c_bub, c_fl;
  logic [1:0]  c_state;
  logic [15:0] c_cyc;

  logic [4:0] st2, st4, st0;
  assign st2 = {a_if, a_id, a_ex, a_bub, a_fl};
  assign st4 = {b_if, b_id, b_ex, b_bub, b_fl};
  assign st0 = {c_if, c_id, c_ex, c_bub, c_fl};

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       mr;
    logic [4:0] wr, rs, rt;
    logic       urs, urt, br;
    logic [4:0] st;
  } vec_t;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_WAIT(2), .CNT_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_write_reg(ex_write_reg), .mem_req(mem_req), .branch_taken(branch_taken),
    .stall_if(a_if), .stall_id(a_id), .stall_ex(a_ex), .bubble_ex(a_bub),
    .flush_id(a_fl), .state_o(a_state), .stall_cycles(a_cyc));

  hazard_ctrl #(.MEM_WAIT(4), .CNT_W(2)) u4 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_write_reg(ex_write_reg), .mem_req(mem_req), .branch_taken(branch_taken),
    .stall_if(b_if), .stall_id(b_id), .stall_ex(b_ex), .bubble_ex(b_bub),
    .flush_id(b_fl), .state_o(b_state), .stall_cycles(b_cyc));

  hazard_ctrl #(.MEM_WAIT(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_write_reg(ex_write_reg), .mem_req(mem_req), .branch_taken(branch_taken),
    .stall_if(c_if), .stall_id(c_id), .stall_ex(c_ex), .bubble_ex(c_bub),
    .flush_id(c_fl), .state_o(c_state), .stall_cycles(c_cyc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic [4:0] wr, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urs, input logic urt, input logic br);
    ex_mem_read = mr; ex_write_reg = wr; id_rs = rs; id_rt = rt;
    id_uses_rs = urs; id_uses_rt = urt; branch_taken = br;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_req = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #7;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_req = 1'b1;
    drive(1'b1, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1);
    #3;
    vectors++; if (st2 !== 5'b0) begin miscompares++; $display("FAIL reset strobes2: got %b want 00000", st2); end
    vectors++; if (a_state !== 2'd0) begin miscompares++; $display("FAIL reset state2: got %0d want 0", a_state); end
    vectors++; if (a_cyc !== 16'd0) begin miscompares++; $display("FAIL reset count2: got %0d want 0", a_cyc); end
    vectors++; if (st4 !== 5'b0) begin miscompares++; $display("FAIL reset strobes4: got %b want 00000", st4); end
    vectors++; if (st0 !== 5'b0) begin miscompares++; $display("FAIL reset strobes0: got %b want 00000", st0); end
  endtask

  task automatic test_mem_stall();
    logic [4:0] exp_st [3];
    logic [1:0] exp_state [3];
    exp_st = '{5'b11100, 5'b11100, 5'b00000};
    exp_state = '{2'd0, 2'd1, 2'd2};
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (st2 !== exp_st[i]) begin miscompares++; $display("FAIL mem_stall strobes c%0d: got %b want %b", i, st2, exp_st[i]); end
      vectors++; if (a_state !== exp_state[i]) begin miscompares++; $display("FAIL mem_stall state c%0d: got %0d want %0d", i, a_state, exp_state[i]); end
      tick();
    end
    mem_req = 1'b0;
    @(negedge clk);
    vectors++; if (a_state !== 2'd0) begin miscompares++; $display("FAIL mem_stall final state: got %0d want 0", a_state); end
    vectors++; if (a_cyc !== 16'd2) begin miscompares++; $display("FAIL mem_stall count: got %0d want 2", a_cyc); end
  endtask

  task automatic test_load_use();
    vec_t tab [6];
    tab[0] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'b11010};
    tab[1] = '{1'b0, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'b00000};
    tab[2] = '{1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b1, 1'b0, 5'b11010};
    tab[3] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'b00000};
    tab[4] = '{1'b1, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 5'b00000};
    tab[5] = '{1'b1, 5'd9, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 5'b00000};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(tab[i].mr, tab[i].wr, tab[i].rs, tab[i].rt, tab[i].urs, tab[i].urt, tab[i].br);
      @(negedge clk);
      vectors++; if (st2 !== tab[i].st) begin miscompares++; $display("FAIL load_use row%0d: got %b want %b", i, st2, tab[i].st); end
      tick();
    end
    @(negedge clk);
    vectors++; if (a_cyc !== 16'd2) begin miscompares++; $display("FAIL load_use count: got %0d want 2", a_cyc); end
  endtask

  task automatic test_branch();
    vec_t tab [3];
    tab[0] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'b11010};
    tab[1] = '{1'b0, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'b00001};
    tab[2] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(tab[i].mr, tab[i].wr, tab[i].rs, tab[i].rt, tab[i].urs, tab[i].urt, tab[i].br);
      @(negedge clk);
      vectors++; if (st2 !== tab[i].st) begin miscompares++; $display("FAIL branch row%0d: got %b want %b", i, st2, tab[i].st); end
      tick();
    end
  endtask

  task automatic test_priority();
    logic [4:0] exp_st [4];
    logic [1:0] exp_state [4];
    exp_st = '{5'b11100, 5'b11100, 5'b11010, 5'b00001};
    exp_state = '{2'd0, 2'd1, 2'd2, 2'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        mem_req = 1'b1;
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1);
      end else begin
        mem_req = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      end
      @(negedge clk);
      vectors++; if (st2 !== exp_st[i]) begin miscompares++; $display("FAIL priority strobes c%0d: got %b want %b", i, st2, exp_st[i]); end
      vectors++; if (a_state !== exp_state[i]) begin miscompares++; $display("FAIL priority state c%0d: got %0d want %0d", i, a_state, exp_state[i]); end
      tick();
    end
  endtask

  task automatic test_reset_in_wait();
    logic [4:0] exp_st [5];
    logic [1:0] exp_state [5];
    exp_st = '{5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b00000};
    exp_state = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    do_reset();
    mem_req = 1'b1;
    tick();
    mem_req = 1'b0;
    tick();
    @(negedge clk);
    vectors++; if (b_state !== 2'd1) begin miscompares++; $display("FAIL rst_wait pre state: got %0d want 1", b_state); end
    vectors++; if (b_cyc !== 2'd2) begin miscompares++; $display("FAIL rst_wait pre count: got %0d want 2", b_cyc); end
    #2;
    mem_req = 1'b1;
    rst_n = 1'b0;
    #1;
    vectors++; if (st4 !== 5'b0) begin miscompares++; $display("FAIL rst_wait strobes: got %b want 00000", st4); end
    vectors++; if (b_state !== 2'd0) begin miscompares++; $display("FAIL rst_wait state: got %0d want 0", b_state); end
    vectors++; if (b_cyc !== 2'd0) begin miscompares++; $display("FAIL rst_wait count: got %0d want 0", b_cyc); end
    mem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (st4 !== exp_st[i]) begin miscompares++; $display("FAIL rst_wait restall strobes c%0d: got %b want %b", i, st4, exp_st[i]); end
      vectors++; if (b_state !== exp_state[i]) begin miscompares++; $display("FAIL rst_wait restall state c%0d: got %0d want %0d", i, b_state, exp_state[i]); end
      tick();
      mem_req = 1'b0;
    end
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    vectors++; if (st4 !== 5'b11010) begin miscompares++; $display("FAIL sat lu strobes: got %b want 11010", st4); end
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++; if (b_cyc !== 2'd3) begin miscompares++; $display("FAIL sat count: got %0d want 3", b_cyc); end
  endtask

  task automatic test_mem_wait0();
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (st0 !== 5'b0) begin miscompares++; $display("FAIL wait0 strobes c%0d: got %b want 00000", i, st0); end
      vectors++; if (c_state !== 2'd0) begin miscompares++; $display("FAIL wait0 state c%0d: got %0d want 0", i, c_state); end
      tick();
    end
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    vectors++; if (st0 !== 5'b11010) begin miscompares++; $display("FAIL wait0 lu: got %b want 11010", st0); end
    tick();
    mem_req = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++; if (c_cyc !== 16'd1) begin miscompares++; $display("FAIL wait0 count: got %0d want 1", c_cyc); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_st [6];
    logic [1:0] exp_state [6];
    exp_st = '{5'b11100, 5'b11100, 5'b00000, 5'b11100, 5'b11100, 5'b00000};
    exp_state = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++; if (st2 !== exp_st[i]) begin miscompares++; $display("FAIL b2b strobes c%0d: got %b want %b", i, st2, exp_st[i]); end
      vectors++; if (a_state !== exp_state[i]) begin miscompares++; $display("FAIL b2b state c%0d: got %0d want %0d", i, a_state, exp_state[i]); end
      tick();
    end
    mem_req = 1'b0;
    @(negedge clk);
    vectors++; if (a_state !== 2'd0) begin miscompares++; $display("FAIL b2b final state: got %0d want 0", a_state); end
    vectors++; if (a_cyc !== 16'd4) begin miscompares++; $display("FAIL b2b count: got %0d want 4", a_cyc); end
  endtask

  initial begin
    #2;
    test_reset();
    test_mem_stall();
    test_load_use();
    test_branch();
    test_priority();
    test_reset_in_wait();
    test_mem_wait0();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
